// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared types, constants and pitch table builder for song_player
package song_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        TONE,
        GAP,
        ADVANCE,
        DONE
    } state_t;

    localparam logic [7:0] REST_NOTE = 8'd0;
    localparam logic [7:0] NOTE_MAX  = 8'd63;
    localparam int         TONE_W    = 20;
    localparam int         LUT_SIZE  = 64;

    // Note 33 is A4 (440 Hz); one index step is one equal-tempered semitone.
    function automatic logic [TONE_W-1:0] half_period(input int n, input int clk_hz);
        real freq;
        real hp;
        int  v;
        freq = 440.0 * (2.0 ** ((real'(n) - 33.0) / 12.0));
        hp   = real'(clk_hz) / (2.0 * freq);
        v    = $rtoi(hp + 0.5);
        if (v < 1) v = 1;
        if (v > (1 << TONE_W) - 1) v = (1 << TONE_W) - 1;
        return TONE_W'(v);
    endfunction

    function automatic logic [LUT_SIZE*TONE_W-1:0] build_period_lut(input int clk_hz);
        logic [LUT_SIZE*TONE_W-1:0] lut;
        lut = '0;
        for (int n = 0; n < LUT_SIZE; n++) begin
            lut[n*TONE_W +: TONE_W] = half_period(n, clk_hz);
        end
        return lut;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave generator toggling every half_period enabled clocks
module tone_gen (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [song_pkg::TONE_W-1:0]  half_period,
    output logic                         square
);

    logic [song_pkg::TONE_W-1:0] cnt;

    // Dropping en restarts the phase so a resumed tone always begins low.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt    <= '0;
            square <= 1'b0;
        end else if (cnt >= half_period - 1'b1) begin
            cnt    <= '0;
            square <= ~square;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/song_player.sv
// rtl/song_player.sv - note ROM sequencer with per-step tone/gap timing and square-wave output
module song_player
    import song_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int NOTE_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int SONG_LEN    = 255,
    parameter int LOOP        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic       restart,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_note,
    output logic       audio,
    output logic [7:0] cur_note,
    output logic       busy,
    output logic       done
);

    localparam int                  STEP_W     = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam logic [STEP_W-1:0]   TONE_LAST  = STEP_W'(NOTE_CYCLES - GAP_CYCLES - 1);
    localparam logic [STEP_W-1:0]   GAP_LAST   = STEP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0]          LAST_ADDR  = 8'(SONG_LEN - 1);
    localparam logic [LUT_SIZE*TONE_W-1:0] PERIOD_LUT = build_period_lut(CLK_HZ);

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step_cnt, step_nxt;
    logic [7:0]          addr_nxt;
    logic [7:0]          note_reg, note_nxt;
    logic                done_nxt;
    logic                sounding;
    logic                tone_en;
    logic                square;
    logic [TONE_W-1:0]   hp_sel;

    // Indices above NOTE_MAX have no table entry and play as rests.
    assign sounding = (note_reg != REST_NOTE) && (note_reg <= NOTE_MAX);
    assign hp_sel   = PERIOD_LUT[note_reg[5:0]*TONE_W +: TONE_W];
    assign tone_en  = (state == TONE) && play && !restart && sounding;
    assign audio    = square & tone_en;
    assign cur_note = ((state == TONE) && sounding) ? note_reg : REST_NOTE;
    assign busy     = (state != IDLE) && (state != DONE);

    tone_gen u_tone_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en),
        .half_period (hp_sel),
        .square      (square)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step_cnt <= '0;
            rom_addr <= 8'd0;
            note_reg <= REST_NOTE;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_nxt;
            rom_addr <= addr_nxt;
            note_reg <= note_nxt;
            done     <= done_nxt;
        end
    end

    // With play low every busy state holds; restart overrides everything.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        addr_nxt  = rom_addr;
        note_nxt  = note_reg;
        done_nxt  = 1'b0;
        if (restart) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            addr_nxt  = 8'd0;
            note_nxt  = REST_NOTE;
        end else begin
            case (state)
                IDLE: begin
                    if (play) state_nxt = FETCH;
                end
                FETCH: begin
                    if (play) state_nxt = LATCH;
                end
                LATCH: begin
                    if (play) begin
                        note_nxt  = rom_note;
                        step_nxt  = '0;
                        state_nxt = TONE;
                    end
                end
                TONE: begin
                    if (play) begin
                        if (step_cnt == TONE_LAST) begin
                            step_nxt  = '0;
                            state_nxt = (GAP_CYCLES > 0) ? GAP : ADVANCE;
                        end else begin
                            step_nxt = step_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (play) begin
                        if (step_cnt == GAP_LAST) begin
                            step_nxt  = '0;
                            state_nxt = ADVANCE;
                        end else begin
                            step_nxt = step_cnt + 1'b1;
                        end
                    end
                end
                ADVANCE: begin
                    if (play) begin
                        if (rom_addr == LAST_ADDR) begin
                            done_nxt = 1'b1;
                            if (LOOP != 0) begin
                                addr_nxt  = 8'd0;
                                state_nxt = FETCH;
                            end else begin
                                state_nxt = DONE;
                            end
                        end else begin
                            addr_nxt  = rom_addr + 8'd1;
                            state_nxt = FETCH;
                        end
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
